// File: rtl/cnt1_arbiter.sv
// cnt1_arbiter: shares one popcount (cnt1) datapath between a reference
// source (S0) and a query source (S1). Whole vectors of SUB_VECTOR_NO words
// are granted round-robin at vector boundaries. The owner of each forwarded
// vector is queued in an in-order tag FIFO, and completed weights are routed
// back to that owner.
// Optional build macro CNT1_ARB_STATS_EN adds per-source vector counters and
// a FIFO occupancy high-water mark.
module cnt1_arbiter #(
   parameter int BUS_WIDTH       = 512,
   parameter int SUB_VECTOR_NO   = 2,
   parameter int CNT_WIDTH       = 10,
   parameter int TAG_DEPTH       = 8,
   parameter int WORD_CNTR_WIDTH = $clog2(SUB_VECTOR_NO+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] i_S0Vector,
   input  logic                 i_S0Valid,
   output logic                 o_S0Ready,
   input  logic [BUS_WIDTH-1:0] i_S1Vector,
   input  logic                 i_S1Valid,
   output logic                 o_S1Ready,
   output logic [BUS_WIDTH-1:0] o_Vector,
   output logic                 o_Valid,
   input  logic [CNT_WIDTH-1:0] i_Cnt,
   input  logic                 i_CntDone,
   output logic [CNT_WIDTH-1:0] o_S0Cnt,
   output logic                 o_S0CntValid,
   output logic [CNT_WIDTH-1:0] o_S1Cnt,
   output logic                 o_S1CntValid,
`ifdef CNT1_ARB_STATS_EN
   output logic [31:0]          o_S0VecCnt,
   output logic [31:0]          o_S1VecCnt,
   output logic [$clog2(TAG_DEPTH+1)-1:0] o_MaxInflight,
`endif
   output logic                 o_TagErr
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int OCC_W = $clog2(TAG_DEPTH+1);

   localparam logic [WORD_CNTR_WIDTH-1:0] LAST_WORD = WORD_CNTR_WIDTH'(SUB_VECTOR_NO-1);
   localparam logic [WORD_CNTR_WIDTH-1:0] WC_ONE    = WORD_CNTR_WIDTH'(1);
   localparam logic [OCC_W-1:0]           DEPTH_C   = OCC_W'(TAG_DEPTH);
   localparam logic [PTR_W-1:0]           PTR_LAST  = PTR_W'(TAG_DEPTH-1);
   localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1);

   logic [0:0]                 state;
   logic                       gnt_id;     // 0 = S0, 1 = S1
   logic                       rr_ptr;     // preferred source on a tie
   logic [WORD_CNTR_WIDTH-1:0] word_cnt;

   logic [TAG_DEPTH-1:0]       tag_mem;
   logic [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic [OCC_W-1:0]           occ, occ_after_pop, occ_nxt;

   logic acc, last_acc, push, pop, grant, grant_id, head_id;

   // Ready depends only on registered state, so it never combinationally
   // follows the requesters' Valid.
   assign o_S0Ready = (state == BURST) && !gnt_id;
   assign o_S1Ready = (state == BURST) &&  gnt_id;

   assign acc      = (o_S0Ready && i_S0Valid) || (o_S1Ready && i_S1Valid);
   assign last_acc = acc && (word_cnt == LAST_WORD);
   assign push     = last_acc;
   assign pop      = i_CntDone && (occ != '0);
   assign head_id  = tag_mem[rd_ptr];

   // A pop in the same cycle frees a slot for the grant being decided now.
   assign occ_after_pop = occ - OCC_W'(pop);
   assign occ_nxt       = occ_after_pop + OCC_W'(push);
   assign grant    = (state == IDLE) && (i_S0Valid || i_S1Valid) && (occ_after_pop < DEPTH_C);
   assign grant_id = (i_S0Valid && i_S1Valid) ? rr_ptr : i_S1Valid;

   // Grant FSM: pick a source in IDLE, stream one whole vector in BURST.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_id   <= 1'b0;
         rr_ptr   <= 1'b0;
         word_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state  <= BURST;
                  gnt_id <= grant_id;
               end
            end
            BURST: begin
               if (acc) begin
                  if (word_cnt == LAST_WORD) begin
                     word_cnt <= '0;
                     rr_ptr   <= ~gnt_id;
                     state    <= IDLE;
                  end else begin
                     word_cnt <= word_cnt + WC_ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag FIFO: owner of every completed vector, oldest at rd_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_mem <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= gnt_id;
            wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         end
         if (pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         occ <= occ_nxt;
      end
   end

   // Forward path: registered copy of each accepted word; data holds on bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_Valid  <= 1'b0;
         o_Vector <= '0;
      end else begin
         o_Valid <= acc;
         if (acc)
            o_Vector <= gnt_id ? i_S1Vector : i_S0Vector;
      end
   end

   // Return path: steer the finished weight to the owner at the FIFO head.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_S0Cnt      <= '0;
         o_S1Cnt      <= '0;
         o_S0CntValid <= 1'b0;
         o_S1CntValid <= 1'b0;
         o_TagErr     <= 1'b0;
      end else begin
         o_S0CntValid <= pop && !head_id;
         o_S1CntValid <= pop &&  head_id;
         if (pop && !head_id) o_S0Cnt <= i_Cnt;
         if (pop &&  head_id) o_S1Cnt <= i_Cnt;
         if (i_CntDone && (occ == '0))
            o_TagErr <= 1'b1;
      end
   end

`ifdef CNT1_ARB_STATS_EN
   // Per-source completed-vector counts and FIFO occupancy high-water mark.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_S0VecCnt    <= '0;
         o_S1VecCnt    <= '0;
         o_MaxInflight <= '0;
      end else begin
         if (push && !gnt_id) o_S0VecCnt <= o_S0VecCnt + 32'd1;
         if (push &&  gnt_id) o_S1VecCnt <= o_S1VecCnt + 32'd1;
         if (occ_nxt > o_MaxInflight) o_MaxInflight <= occ_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_cnt1_arbiter.sv
// Bench for cnt1_arbiter: a hand-derived contention table, directed
// sequences for multi-cycle corners, then random traffic against a
// queue-based reference model.
module tb_cnt1_arbiter;

   localparam int BW    = 512;
   localparam int SUB   = 2;
   localparam int CW    = 10;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] s0_vec = '0, s1_vec = '0;
   logic          s0_valid = 1'b0, s1_valid = 1'b0;
   logic          s0_ready, s1_ready;
   logic [BW-1:0] out_vec;
   logic          out_valid;
   logic [CW-1:0] cnt_in = '0;
   logic          cnt_done = 1'b0;
   logic [CW-1:0] s0_cnt, s1_cnt;
   logic          s0_cnt_valid, s1_cnt_valid;
   logic          tag_err;
`ifdef CNT1_ARB_STATS_EN
   logic [31:0]   s0_vec_cnt, s1_vec_cnt;
   logic [$clog2(DEPTH+1)-1:0] max_infl;
`endif

   always #5 clk = ~clk;

   cnt1_arbiter #(.BUS_WIDTH(BW), .SUB_VECTOR_NO(SUB), .CNT_WIDTH(CW), .TAG_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .i_S0Vector(s0_vec), .i_S0Valid(s0_valid), .o_S0Ready(s0_ready),
      .i_S1Vector(s1_vec), .i_S1Valid(s1_valid), .o_S1Ready(s1_ready),
      .o_Vector(out_vec), .o_Valid(out_valid),
      .i_Cnt(cnt_in), .i_CntDone(cnt_done),
      .o_S0Cnt(s0_cnt), .o_S0CntValid(s0_cnt_valid),
      .o_S1Cnt(s1_cnt), .o_S1CntValid(s1_cnt_valid),
`ifdef CNT1_ARB_STATS_EN
      .o_S0VecCnt(s0_vec_cnt), .o_S1VecCnt(s1_vec_cnt), .o_MaxInflight(max_infl),
`endif
      .o_TagErr(tag_err)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit            m_busy, m_owner, m_rr, m_err, m_ov, m_c0v, m_c1v;
   int            m_words;
   int            q[$];          // owners of vectors waiting for a weight
   logic [BW-1:0] m_vec;
   logic [CW-1:0] m_c0, m_c1;
   int            m_vc0, m_vc1, m_max;
   int            got0[$], got1[$];
   int            words_out;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_rr = 0; m_err = 0; m_ov = 0;
      m_c0v = 0; m_c1v = 0; m_words = 0; q.delete();
      m_vec = '0; m_c0 = '0; m_c1 = '0; m_vc0 = 0; m_vc1 = 0; m_max = 0;
   endtask

   // One clock: drive inputs, predict, clock, compare.
   task automatic step(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1,
                       input bit done, input logic [CW-1:0] c);
      int id;
      s0_valid = v0; s1_valid = v1; s0_vec = {16{d0}}; s1_vec = {16{d1}};
      cnt_done = done; cnt_in = c;
      chk("S0Ready", s0_ready, m_busy && !m_owner);
      chk("S1Ready", s1_ready, m_busy &&  m_owner);
      m_c0v = 0; m_c1v = 0; m_ov = 0;
      if (done) begin
         if (q.size() > 0) begin
            id = q.pop_front();
            if (id == 0) begin m_c0v = 1; m_c0 = c; end
            else         begin m_c1v = 1; m_c1 = c; end
         end else m_err = 1;
      end
      if (m_busy) begin
         if ((m_owner == 0 && v0) || (m_owner == 1 && v1)) begin
            m_ov = 1;
            m_vec = m_owner ? {16{d1}} : {16{d0}};
            m_words++;
            if (m_words == SUB) begin
               q.push_back(int'(m_owner));
               if (m_owner) m_vc1++; else m_vc0++;
               m_rr = !m_owner; m_busy = 0; m_words = 0;
            end
         end
      end else if ((v0 || v1) && q.size() < DEPTH) begin
         m_owner = (v0 && v1) ? m_rr : v1;
         m_busy = 1; m_words = 0;
      end
      if (q.size() > m_max) m_max = q.size();
      @(posedge clk); #1;
      chk("o_Valid", out_valid, m_ov);
      chk("o_Vector", out_vec, m_vec);
      chk("S0CntValid", s0_cnt_valid, m_c0v);
      chk("S1CntValid", s1_cnt_valid, m_c1v);
      chk("S0Cnt", s0_cnt, m_c0);
      chk("S1Cnt", s1_cnt, m_c1);
      chk("TagErr", tag_err, m_err);
`ifdef CNT1_ARB_STATS_EN
      chk("S0VecCnt", s0_vec_cnt, m_vc0);
      chk("S1VecCnt", s1_vec_cnt, m_vc1);
      chk("MaxInflight", max_infl, m_max);
`endif
      if (out_valid) words_out++;
      if (s0_cnt_valid) got0.push_back(int'(s0_cnt));
      if (s1_cnt_valid) got1.push_back(int'(s1_cnt));
   endtask

   task automatic do_reset(input bit v0);
      rst = 1; s0_valid = v0; s1_valid = 0; cnt_done = 0;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      chk("rst S0Ready", s0_ready, 1'b0);
      chk("rst S1Ready", s1_ready, 1'b0);
      chk("rst o_Valid", out_valid, 1'b0);
      chk("rst o_Vector", out_vec, '0);
      chk("rst CntValid", {s0_cnt_valid, s1_cnt_valid}, 2'b00);
      chk("rst Cnt", {s0_cnt, s1_cnt}, '0);
      chk("rst TagErr", tag_err, 1'b0);
      got0.delete(); got1.delete(); words_out = 0;
   endtask

   // ---------------- contention table ----------------
   typedef struct {
      bit s0v, s1v, done; logic [CW-1:0] cnt;
      bit r0, r1, ov; logic [31:0] od; bit c0v, c1v; logic [CW-1:0] ecnt;
   } vec_t;
   vec_t tbl[8];

   initial begin
      // Row i drives S0 data 'hA0+i and S1 data 'hB0+i.
      tbl[0] = '{1,1,0,0,  0,0,0,32'h00, 0,0,0};
      tbl[1] = '{1,1,0,0,  1,0,1,32'hA1, 0,0,0};
      tbl[2] = '{1,1,0,0,  1,0,1,32'hA2, 0,0,0};
      tbl[3] = '{1,1,1,5,  0,0,0,32'hA2, 1,0,5};
      tbl[4] = '{1,1,0,0,  0,1,1,32'hB4, 0,0,0};
      tbl[5] = '{1,1,0,0,  0,1,1,32'hB5, 0,0,0};
      tbl[6] = '{1,1,1,7,  0,0,0,32'hB5, 0,1,7};
      tbl[7] = '{1,1,0,0,  1,0,1,32'hA7, 0,0,0};

      do_reset(0);
      for (int i = 0; i < 8; i++) begin
         s0_valid = tbl[i].s0v; s1_valid = tbl[i].s1v;
         s0_vec = {16{32'hA0 + i}}; s1_vec = {16{32'hB0 + i}};
         cnt_done = tbl[i].done; cnt_in = tbl[i].cnt;
         chk("tbl S0Ready", s0_ready, tbl[i].r0);
         chk("tbl S1Ready", s1_ready, tbl[i].r1);
         @(posedge clk); #1;
         chk("tbl o_Valid", out_valid, tbl[i].ov);
         chk("tbl o_Vector", out_vec, {16{tbl[i].od}});
         chk("tbl S0CntValid", s0_cnt_valid, tbl[i].c0v);
         chk("tbl S1CntValid", s1_cnt_valid, tbl[i].c1v);
         if (tbl[i].c0v) chk("tbl S0Cnt", s0_cnt, tbl[i].ecnt);
         if (tbl[i].c1v) chk("tbl S1Cnt", s1_cnt, tbl[i].ecnt);
      end

      // Single source: three S0 vectors, weights 5, 7, 9 come back to S0.
      do_reset(0);
      for (int i = 0; i < 15; i++)
         step(i < 9, 0, 32'h1000 + i, 32'h0, (i == 10 || i == 12 || i == 14),
              (i == 10) ? 10'd5 : (i == 12) ? 10'd7 : 10'd9);
      chk("single S0 pulses", got0.size(), 3);
      chk("single S1 pulses", got1.size(), 0);
      if (got0.size() == 3) begin
         chk("single w0", got0[0], 5);
         chk("single w1", got0[1], 7);
         chk("single w2", got0[2], 9);
      end

      // Bubble: S1 stalls 3 cycles mid-vector while S0 is requesting.
      do_reset(0);
      step(0, 1, 32'h0, 32'h2000, 0, 0);   // grant S1
      step(0, 1, 32'h0, 32'h2001, 0, 0);   // word 0
      for (int i = 0; i < 3; i++)
         step(1, 0, 32'h3000 + i, 32'h0, 0, 0);
      step(1, 1, 32'h3003, 32'h2002, 0, 0); // word 1, tag pushed
      for (int i = 0; i < 3; i++)
         step(1, 0, 32'h3010 + i, 32'h0, 0, 0);
      step(0, 0, 0, 0, 1, 10'd33);
      step(0, 0, 0, 0, 1, 10'd44);
      chk("bubble words", words_out, 4);
      chk("bubble S1 pulses", got1.size(), 1);
      chk("bubble S0 pulses", got0.size(), 1);
      if (got1.size() == 1) chk("bubble S1 weight", got1[0], 33);

      // Backpressure: FIFO fills at DEPTH vectors, one pop admits exactly one more.
      do_reset(0);
      for (int i = 0; i < 40; i++) step(1, 1, 32'h4000 + i, 32'h5000 + i, 0, 0);
      chk("bp words at full", words_out, DEPTH * SUB);
      step(1, 1, 32'h4100, 32'h5100, 1, 10'd1);
      for (int i = 0; i < 20; i++) step(1, 1, 32'h4200 + i, 32'h5200 + i, 0, 0);
      chk("bp words after pop", words_out, (DEPTH + 1) * SUB);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, CW'(100 + i));
      chk("bp S0 pulses", got0.size(), 5);
      chk("bp S1 pulses", got1.size(), 4);

      // Error then reset mid-burst.
      do_reset(0);
      step(0, 0, 0, 0, 1, 10'd3);
      chk("err flag", tag_err, 1'b1);
      step(1, 0, 32'h6000, 0, 0, 0);
      step(1, 0, 32'h6001, 0, 0, 0);
      do_reset(1);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h7000 + i, 0, 0, 0);
      step(0, 0, 0, 0, 1, 10'd77);
      chk("post-rst words", words_out, 2);
      chk("post-rst S0 pulses", got0.size(), 1);
      chk("post-rst TagErr", tag_err, 1'b0);

      // Random traffic against the model.
      do_reset(0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 3) == 0, CW'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
